// File: rtl/simon_input_checker.sv
// Simon Says user-turn input checker: synchronises and debounces KEY[3:0],
// encodes single presses to colours and checks them against the sequence RAM.
module simon_input_checker #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000,
  parameter int unsigned ADDR_W          = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   round_len,
  input  logic [3:0]        key,
  output logic [ADDR_W-1:0] seq_addr,
  input  logic [1:0]        seq_data,
  output logic              busy,
  output logic              press_valid,
  output logic [1:0]        press_color,
  output logic              pass,
  output logic              fail
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_CHECK, S_PASS, S_FAIL
  } state_t;

  state_t state, state_n;

  logic [3:0]        key_s1, key_s2;
  logic [DW-1:0]     db_cnt [4];
  logic [3:0]        db, db_q;
  logic              press_evt;
  logic [1:0]        press_code;
  logic [ADDR_W:0]   len, len_clamped;
  logic [ADDR_W-1:0] idx;
  logic [TW-1:0]     timer;

  // Raw keys are active-low; synchroniser flops reset to the released level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end

  // db holds the debounced pressed level (1 = pressed).
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
      db   <= '0;
      db_q <= '0;
    end else begin
      db_q <= db;
      for (int unsigned i = 0; i < 4; i++) begin
        if (~key_s2[i] != db[i]) begin
          if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            db[i]     <= ~key_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Only a fresh edge with exactly one key down counts; held keys never re-fire.
  assign press_evt = (|(db & ~db_q)) && $onehot(db);

  always_comb begin
    press_code = 2'b00;
    case (db)
      4'b0010: press_code = 2'b01;
      4'b0100: press_code = 2'b10;
      4'b1000: press_code = 2'b11;
      default: press_code = 2'b00;
    endcase
  end

  assign len_clamped = (round_len > MAX_LEN) ? MAX_LEN : round_len;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = (len_clamped == '0) ? S_PASS : S_FETCH;
      S_FETCH: state_n = S_WAIT;
      S_WAIT: begin
        if (press_evt)                          state_n = S_CHECK;
        else if (timer == TW'(TIMEOUT_CYCLES - 1)) state_n = S_FAIL;
      end
      S_CHECK: begin
        if (press_color != seq_data)            state_n = S_FAIL;
        else if ({1'b0, idx} == len - 1'b1)     state_n = S_PASS;
        else                                    state_n = S_FETCH;
      end
      S_PASS:  state_n = S_IDLE;
      S_FAIL:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      len         <= '0;
      idx         <= '0;
      timer       <= '0;
      press_color <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          len <= len_clamped;
          idx <= '0;
        end
        S_FETCH: timer <= '0;
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (press_evt) press_color <= press_code;
        end
        S_CHECK: if (state_n == S_FETCH) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign seq_addr = idx;

  always_comb begin
    busy        = (state != S_IDLE);
    press_valid = (state == S_CHECK);
    pass        = (state == S_PASS);
    fail        = (state == S_FAIL);
  end

endmodule

// File: tb/tb_simon_input_checker.sv
// Directed bench for simon_input_checker with a registered sequence RAM model.
module tb_simon_input_checker;

  localparam int unsigned AW = 5;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   round_len;
  logic [3:0]    key;
  logic [AW-1:0] seq_addr;
  logic [1:0]    seq_data;
  logic          busy, press_valid, pass, fail;
  logic [1:0]    press_color;

  logic [1:0] ram [32];
  int n_assert = 0;
  int n_fail   = 0;
  int pv_cnt = 0, pass_cnt = 0, fail_cnt = 0, both_cnt = 0;
  int pv0, pass0, fail0;

  simon_input_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64),
    .ADDR_W         (AW)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .start      (start),
    .round_len  (round_len),
    .key        (key),
    .seq_addr   (seq_addr),
    .seq_data   (seq_data),
    .busy       (busy),
    .press_valid(press_valid),
    .press_color(press_color),
    .pass       (pass),
    .fail       (fail)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) seq_data <= ram[seq_addr];

  always @(negedge CLOCK_50) begin
    if (press_valid) pv_cnt++;
    if (pass) pass_cnt++;
    if (fail) fail_cnt++;
    if (pass && fail) both_cnt++;
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_round(input logic [AW:0] len);
    round_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Press key k and stop at the cycle press_valid is seen.
  task automatic press(input int unsigned k, input logic [1:0] exp_c);
    bit found = 0;
    key[k] = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (press_valid) found = 1;
    end
    check("press_seen", 32'(found), 32'd1);
    check("press_color", 32'(press_color), 32'(exp_c));
  endtask

  task automatic release_keys();
    key = 4'hF;
    repeat (10) step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; round_len = '0; key = 4'hF;
    for (int i = 0; i < 32; i++) ram[i] = 2'd0;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pv", 32'(press_valid), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_addr", 32'(seq_addr), 32'd0);
    check("rst_color", 32'(press_color), 32'd0);
    reset = 1'b0;
    step();

    // 1: correct three-press round
    ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
    start_round(6'd3);
    check("t1_busy", 32'(busy), 32'd1);
    press(2, 2'd2); release_keys();
    press(0, 2'd0); release_keys();
    press(3, 2'd3);
    step();
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_nofail", 32'(fail), 32'd0);
    step();
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_pass_end", 32'(pass), 32'd0);
    release_keys();

    // 2: wrong second colour
    ram[0] = 2'd1; ram[1] = 2'd1;
    start_round(6'd2);
    press(1, 2'd1); release_keys();
    press(3, 2'd3);
    check("t2_addr", 32'(seq_addr), 32'd1);
    step();
    check("t2_fail", 32'(fail), 32'd1);
    check("t2_nopass", 32'(pass), 32'd0);
    step();
    check("t2_busy_end", 32'(busy), 32'd0);
    check("t2_addr_end", 32'(seq_addr), 32'd1);
    release_keys();

    // 3: bounce on KEY0 then hold
    ram[0] = 2'd0;
    pv0 = pv_cnt; pass0 = pass_cnt;
    start_round(6'd1);
    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      step(); step();
    end
    key[0] = 1'b0;
    repeat (20) step();
    check("t3_one_press", 32'(pv_cnt - pv0), 32'd1);
    check("t3_pass", 32'(pass_cnt - pass0), 32'd1);
    release_keys();

    // 4: two keys together, then timeout
    pv0 = pv_cnt;
    start_round(6'd1);
    key = 4'b1100;
    repeat (64) step();
    check("t4_no_fail_yet", 32'(fail), 32'd0);
    step();
    check("t4_timeout_fail", 32'(fail), 32'd1);
    check("t4_no_press", 32'(pv_cnt - pv0), 32'd0);
    release_keys();

    // 5: zero-length round, then start ignored while busy
    start_round(6'd0);
    check("t5_pass0", 32'(pass), 32'd1);
    step();
    check("t5_busy0", 32'(busy), 32'd0);
    ram[0] = 2'd3;
    pass0 = pass_cnt;
    start_round(6'd1);
    repeat (3) step();
    round_len = 6'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("t5_still_busy", 32'(busy), 32'd1);
    check("t5_no_restart", 32'(pass_cnt - pass0), 32'd0);
    press(3, 2'd3);
    step();
    check("t5_pass1", 32'(pass), 32'd1);
    release_keys();

    // clamp: round_len 40 behaves as 32
    for (int i = 0; i < 32; i++) ram[i] = 2'(i % 4);
    start_round(6'd40);
    for (int i = 0; i < 32; i++) begin
      press(i % 4, 2'(i % 4));
      if (i < 31) release_keys();
    end
    check("clamp_addr", 32'(seq_addr), 32'd31);
    step();
    check("clamp_pass", 32'(pass), 32'd1);
    release_keys();

    // 6: reset in WAIT at idx 1
    ram[0] = 2'd0; ram[1] = 2'd0;
    pass0 = pass_cnt; fail0 = fail_cnt;
    start_round(6'd2);
    press(0, 2'd0);
    release_keys();
    check("t6_addr", 32'(seq_addr), 32'd1);
    check("t6_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(seq_addr), 32'd0);
    check("t6_rst_pv", 32'(press_valid), 32'd0);
    step();
    reset = 1'b0;
    repeat (5) step();
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_no_pulse", 32'((pass_cnt - pass0) + (fail_cnt - fail0)), 32'd0);

    check("total_pass", 32'(pass_cnt), 32'd5);
    check("total_fail", 32'(fail_cnt), 32'd2);
    check("pass_fail_excl", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
